// File: rtl/bounded_counter_pkg.sv
// Shared types, default parameters and the saturating adder for the
// bounded step counter bank.
package bounded_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } chan_state_t;

  localparam int DEF_W      = 10;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_START  = 1;
  localparam int DEF_LIMIT  = 300;
  localparam int DEF_STEP_W = 4;

  // Adds a and b one bit wider than the operands and clamps the result to
  // 2**w-1. Bit 32 of the return value flags that the clamp was applied;
  // bits [31:0] hold the (possibly clamped) sum. w must be below 32.
  function automatic logic [32:0] sat_add(input int unsigned w,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    if (s > m) return {1'b1, m[31:0]};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/bounded_step_channel.sv
// One bounded index/sum channel: RUN/DONE state machine, index, saturating
// running sum, sticky overflow flag and the channel's own invariants.
module bounded_step_channel
  import bounded_counter_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int START  = DEF_START,
  parameter int LIMIT  = DEF_LIMIT,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [STEP_W-1:0] step,
  output logic [W-1:0]      idx,
  output logic [W-1:0]      sum,
  output logic              done,
  output logic              ovf
);

  localparam logic [W-1:0] START_V = W'(START);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
  localparam logic [W-1:0] END_V   = W'(LIMIT + 1);
  localparam logic [W-1:0] RUN_LEN = W'(LIMIT - START + 1);

  chan_state_t state_p0, state_nx;
  logic [W-1:0] idx_p0, idx_nx;
  logic [W-1:0] sum_p0, sum_nx;
  logic         ovf_p0, ovf_nx;
  logic         adv;
  logic [32:0]  sat_sum;

  // Tracks whether every committed step since the last clear/reset was 1;
  // only the unit-step invariant below looks at it.
  logic         unit_p0;

  // State register: RUN after reset, otherwise follows the next-state logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p0 <= RUN;
    else      state_p0 <= state_nx;
  end

  // Index, sum and overflow registers; reset discards all progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_p0  <= START_V;
      sum_p0  <= '0;
      ovf_p0  <= 1'b0;
      unit_p0 <= 1'b1;
    end else begin
      idx_p0  <= idx_nx;
      sum_p0  <= sum_nx;
      ovf_p0  <= ovf_nx;
      if (clr)      unit_p0 <= 1'b1;
      else if (adv) unit_p0 <= unit_p0 & (step == STEP_W'(1));
    end
  end

  // Clear beats advance beats hold; the LIMIT->LIMIT+1 advance enters DONE.
  always_comb begin
    state_nx = state_p0;
    idx_nx   = idx_p0;
    sum_nx   = sum_p0;
    ovf_nx   = ovf_p0;
    adv      = (state_p0 == RUN) && en && (idx_p0 <= LIMIT_V);
    sat_sum  = sat_add(W, 32'(sum_p0), 32'(step));
    if (clr) begin
      state_nx = RUN;
      idx_nx   = START_V;
      sum_nx   = '0;
      ovf_nx   = 1'b0;
    end else if (adv) begin
      idx_nx = idx_p0 + W'(1);
      sum_nx = sat_sum[W-1:0];
      if (sat_sum[32])        ovf_nx   = 1'b1;
      if (idx_p0 == LIMIT_V)  state_nx = DONE;
    end
  end

  assign idx  = idx_p0;
  assign sum  = sum_p0;
  assign ovf  = ovf_p0;
  assign done = (state_p0 == DONE);

  a_idx_range: assert property (@(posedge clk) disable iff (!rst)
    (idx_p0 >= START_V) && (idx_p0 <= END_V));

  a_done_idx: assert property (@(posedge clk) disable iff (!rst)
    done == (idx_p0 == END_V));

  a_sum_bound: assert property (@(posedge clk) disable iff (!rst)
    !ovf_p0 |-> (int'(sum_p0) <= (int'(idx_p0) - START) * (2**STEP_W - 1)));

  a_unit_sum: assert property (@(posedge clk) disable iff (!rst)
    (done && unit_p0) |-> (sum_p0 == RUN_LEN));

endmodule

// File: rtl/bounded_step_counter_bank.sv
// Bank of NUM_CH independent bounded step counters with packed outputs and
// an all-channels-complete flag.
module bounded_step_counter_bank
  import bounded_counter_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int START  = DEF_START,
  parameter int LIMIT  = DEF_LIMIT,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        en,
  input  logic [NUM_CH-1:0]        clr,
  input  logic [NUM_CH*STEP_W-1:0] step,
  output logic [NUM_CH*W-1:0]      i_out,
  output logic [NUM_CH*W-1:0]      sn_out,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        ovf,
  output logic                     all_done
);

  // LIMIT+1 must still fit in W bits so the index never wraps.
  if ((LIMIT < START) || (LIMIT > (2**W - 2))) begin : g_bad_bounds
    $error("bounded_step_counter_bank: need START <= LIMIT <= 2**W-2");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bounded_step_channel #(
      .W      (W),
      .START  (START),
      .LIMIT  (LIMIT),
      .STEP_W (STEP_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en[c]),
      .clr  (clr[c]),
      .step (step[c*STEP_W +: STEP_W]),
      .idx  (i_out[c*W +: W]),
      .sum  (sn_out[c*W +: W]),
      .done (done[c]),
      .ovf  (ovf[c])
    );
  end

  assign all_done = &done;

endmodule

// File: tb/tb_bounded_step_counter_bank.sv
// Scoreboard bench for bounded_step_counter_bank: directed scenarios plus a
// long randomized run, all compared against an index/sum reference model.
module tb_bounded_step_counter_bank;

  localparam int W      = 10;
  localparam int NUM_CH = 4;
  localparam int START  = 1;
  localparam int LIMIT  = 300;
  localparam int STEP_W = 4;
  localparam int MAXV   = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH-1:0]        clr;
  logic [NUM_CH*STEP_W-1:0] step;
  logic [NUM_CH*W-1:0]      i_out;
  logic [NUM_CH*W-1:0]      sn_out;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        ovf;
  logic                     all_done;

  always #5 clk = ~clk;

  bounded_step_counter_bank #(
    .W(W), .NUM_CH(NUM_CH), .START(START), .LIMIT(LIMIT), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .step(step),
    .i_out(i_out), .sn_out(sn_out), .done(done), .ovf(ovf),
    .all_done(all_done)
  );

  typedef struct packed {
    logic [NUM_CH*W-1:0] i;
    logic [NUM_CH*W-1:0] sn;
    logic [NUM_CH-1:0]   done;
    logic [NUM_CH-1:0]   ovf;
    logic                all_done;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain integers per channel.
  int m_i  [NUM_CH];
  int m_sn [NUM_CH];
  bit m_ovf[NUM_CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_i[c] = START; m_sn[c] = 0; m_ovf[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr[c]) begin
        m_i[c] = START; m_sn[c] = 0; m_ovf[c] = 0;
      end else if (en[c] && m_i[c] <= LIMIT) begin
        m_i[c]  = m_i[c] + 1;
        m_sn[c] = m_sn[c] + int'(step[c*STEP_W +: STEP_W]);
        if (m_sn[c] > MAXV) begin
          m_sn[c]  = MAXV;
          m_ovf[c] = 1;
        end
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e.i[c*W +: W]  = W'(m_i[c]);
      e.sn[c*W +: W] = W'(m_sn[c]);
      e.done[c]      = (m_i[c] == LIMIT + 1);
      e.ovf[c]       = m_ovf[c];
    end
    e.all_done = &e.done;
    return e;
  endfunction

  // One clock: the model consumes the same inputs the DUT samples, the
  // expected outputs are queued, and control returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    q.push_back(snapshot());
    @(negedge clk);
  endtask

  task automatic set_step(input int c, input int v);
    step[c*STEP_W +: STEP_W] = STEP_W'(v);
  endtask

  function automatic logic [W-1:0] ch_i(input int c);
    return i_out[c*W +: W];
  endfunction

  function automatic logic [W-1:0] ch_sn(input int c);
    return sn_out[c*W +: W];
  endfunction

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("sb_i_ch%0d", c),    ch_i(c),  e.i[c*W +: W]);
        chk($sformatf("sb_sn_ch%0d", c),   ch_sn(c), e.sn[c*W +: W]);
        chk($sformatf("sb_done_ch%0d", c), done[c],  e.done[c]);
        chk($sformatf("sb_ovf_ch%0d", c),  ovf[c],   e.ovf[c]);
      end
      chk("sb_all_done", all_done, e.all_done);
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst  = 1'b0;
    en   = '0;
    clr  = '0;
    step = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("rst_i_ch%0d", c),  ch_i(c),  START);
      chk($sformatf("rst_sn_ch%0d", c), ch_sn(c), 0);
    end
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_all_done", all_done, 0);
    rst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) set_step(c, 1);

    // Full run on ch0 with unit step.
    en = 4'b0001;
    repeat (300) cycle();
    chk("run_i", ch_i(0), 301);
    chk("run_sn", ch_sn(0), 300);
    chk("run_done", done[0], 1);
    chk("run_ovf", ovf[0], 0);
    repeat (5) cycle();
    chk("run_hold_i", ch_i(0), 301);
    chk("run_hold_sn", ch_sn(0), 300);

    // Gated enable on ch1.
    for (int k = 0; k < 20; k++) begin
      en = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      cycle();
    end
    en = '0;
    chk("gate_i", ch_i(1), 11);
    chk("gate_sn", ch_sn(1), 10);
    chk("gate_done", done[1], 0);

    // Saturation on ch2 with the largest step.
    set_step(2, 15);
    en = 4'b0100;
    repeat (68) cycle();
    chk("sat68_sn", ch_sn(2), 1020);
    chk("sat68_ovf", ovf[2], 0);
    cycle();
    chk("sat69_sn", ch_sn(2), 1023);
    chk("sat69_ovf", ovf[2], 1);
    cycle();
    chk("sat70_i", ch_i(2), 71);
    chk("sat70_sn", ch_sn(2), 1023);
    chk("sat70_ovf", ovf[2], 1);
    set_step(2, 1);

    // Clear wins over a same-edge advance on ch3.
    en = 4'b1000;
    repeat (149) cycle();
    chk("clr_pre_i", ch_i(3), 150);
    clr = 4'b1000;
    cycle();
    clr = '0;
    chk("clr_i", ch_i(3), 1);
    chk("clr_sn", ch_sn(3), 0);
    chk("clr_ovf", ovf[3], 0);
    repeat (300) cycle();
    chk("clr_done", done[3], 1);
    chk("clr_all_done_partial", all_done, 0);
    en = 4'b1111;
    repeat (300) cycle();
    chk("all_done_full", all_done, 1);
    chk("ovf2_sticky", ovf[2], 1);

    // Asynchronous reset in the middle of a run.
    clr = 4'b0001;
    cycle();
    clr = '0;
    en  = 4'b0001;
    repeat (199) cycle();
    en = '0;
    chk("ar_pre_i", ch_i(0), 200);
    #2 rst = 1'b0;
    #1;
    chk("ar_i", ch_i(0), START);
    chk("ar_sn", ch_sn(0), 0);
    chk("ar_done", done, 0);
    chk("ar_all_done", all_done, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Randomized independent traffic on all channels.
    for (int k = 0; k < 5000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]  = ($urandom_range(3) != 0);
        clr[c] = ($urandom_range(255) == 0);
        if ($urandom_range(1) == 1) set_step(c, 1);
        else                        set_step(c, int'($urandom_range(15)));
      end
      cycle();
    end
    en  = '0;
    clr = '0;

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
